// File: rtl/rca_seq_ctrl_pkg.sv
// rtl/rca_seq_ctrl_pkg.sv - shared types and constants for the byte-serial adder controller
package rca_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BYTE_W = 8;

  function automatic int idx_w(input int nbytes);
    return (nbytes <= 1) ? 1 : $clog2(nbytes);
  endfunction

endpackage

// File: rtl/rca_seq_ctrl_if.sv
// rtl/rca_seq_ctrl_if.sv - operand/result handshake bundle for rca_seq_ctrl
interface rca_seq_ctrl_if
  import rca_seq_pkg::*;
#(
  parameter int NBYTES = 4
);
  localparam int WIDTH = BYTE_W * NBYTES;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/rca_seq_ctrl_byte_adder_slice.sv
// rtl/rca_seq_ctrl_byte_adder_slice.sv - 8-bit adder slice with carry-in and carry-out
module byte_adder_slice
  import rca_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              ci,
  output logic [BYTE_W-1:0] s,
  output logic              co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, ci};
endmodule

// File: rtl/rca_seq_ctrl.sv
// rtl/rca_seq_ctrl.sv - wide addition by reusing one byte slice over NBYTES cycles, LSB first
module rca_seq_ctrl
  import rca_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input logic          clk,
  input logic          rst,
  rca_seq_ctrl_if.slave bus
);
  localparam int WIDTH = BYTE_W * NBYTES;
  localparam int IW    = idx_w(NBYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  a_reg, b_reg, sum_reg;
  logic              carry, cout_reg, ovf_reg;
  logic [IW-1:0]     idx;
  logic [BYTE_W-1:0] slice_a, slice_b, slice_s;
  logic              slice_co;
  logic              accept, last;

  assign accept = (state == IDLE) && bus.in_valid;
  assign last   = (idx == LAST_IDX);

  assign slice_a = a_reg[idx*BYTE_W +: BYTE_W];
  assign slice_b = b_reg[idx*BYTE_W +: BYTE_W];

  byte_adder_slice u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)        state_nxt = RUN;
      RUN:     if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // The carry register threads the ripple between consecutive byte slices.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg <= bus.a;
            b_reg <= bus.b;
            carry <= bus.cin;
            idx   <= '0;
          end
        end
        RUN: begin
          sum_reg[idx*BYTE_W +: BYTE_W] <= slice_s;
          carry <= slice_co;
          if (last) begin
            cout_reg <= slice_co;
            // a^b^s at the MSB recovers the carry into bit WIDTH-1.
            ovf_reg  <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ slice_s[BYTE_W-1] ^ slice_co;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
  assign bus.ovf       = ovf_reg;
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// tb/tb_rca_seq_ctrl.sv - randomized and directed bench for rca_seq_ctrl against an arithmetic model
module tb_rca_seq_ctrl;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rca_seq_ctrl_if #(.NBYTES(NB)) bus ();
  rca_seq_ctrl #(.NBYTES(NB)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Returns {ovf, cout, sum} computed from plain arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [W:0] full;
    logic       o;
    full = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
    o    = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return {o, full};
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input int hold,
                        output logic [W+1:0] res, output int lat);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin tick; guard++; end
    bus.a = a; bus.b = b; bus.cin = ci; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    tick;
    bus.in_valid = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin tick; lat++; end
    repeat (hold) tick;
    res = {bus.ovf, bus.cout, bus.sum};
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (2) tick;
    n_cmp++; if (bus.in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if ({bus.ovf, bus.cout, bus.sum} !== '0)
      begin n_err++; $display("FAIL reset_result got ovf=%b cout=%b sum=%h want all zero", bus.ovf, bus.cout, bus.sum); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_directed;
    logic [W-1:0] va [3] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [W-1:0] vb [3] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0001};
    logic         vc [3] = '{1'b0, 1'b1, 1'b0};
    logic [W+1:0] ve [3] = '{{2'b00, 32'h0000_0100}, {2'b01, 32'h0000_0000}, {2'b10, 32'h8000_0000}};
    logic [W+1:0] res;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], vc[i], 0, res, lat);
      n_cmp++; if (res !== ve[i])
        begin n_err++; $display("FAIL directed_%0d got {ovf,cout,sum}=%h want %h", i, res, ve[i]); end
      n_cmp++; if (lat !== NB)
        begin n_err++; $display("FAIL directed_latency_%0d got %0d want %0d", i, lat, NB); end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b;
    logic         ci;
    logic [W+1:0] res, exp;
    int lat;
    for (int i = 0; i < 24; i++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      ci = 1'($urandom);
      if (i % 6 == 0) b = ~a;
      exp = model(a, b, ci);
      run_op(a, b, ci, int'($urandom_range(3)), res, lat);
      n_cmp++; if (res !== exp)
        begin n_err++; $display("FAIL random_%0d a=%h b=%h cin=%b got %h want %h", i, a, b, ci, res, exp); end
      n_cmp++; if (lat !== NB)
        begin n_err++; $display("FAIL random_latency_%0d got %0d want %0d", i, lat, NB); end
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] a, b;
    logic [W+1:0] exp, got;
    int guard;
    a = W'($urandom); b = W'($urandom);
    exp = model(a, b, 1'b1);
    bus.a = a; bus.b = b; bus.cin = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    tick;
    bus.in_valid = 1'b0;
    tick;
    bus.a = ~a; bus.b = a; bus.cin = 1'b0; bus.in_valid = 1'b1;
    n_cmp++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1)
      begin n_err++; $display("FAIL bp_run_flags got in_ready=%b busy=%b want 0 1", bus.in_ready, bus.busy); end
    tick;
    bus.in_valid = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 100) begin tick; guard++; end
    for (int c = 0; c < 10; c++) begin
      got = {bus.ovf, bus.cout, bus.sum};
      n_cmp++; if (got !== exp || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
        begin n_err++; $display("FAIL bp_hold_%0d got %h in_ready=%b out_valid=%b want %h 0 1",
                                c, got, bus.in_ready, bus.out_valid, exp); end
      tick;
    end
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0)
      begin n_err++; $display("FAIL bp_release got out_valid=%b in_ready=%b busy=%b want 0 1 0",
                              bus.out_valid, bus.in_ready, bus.busy); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a, b;
    logic [W+1:0] exp;
    int cnt, seen;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = W'($urandom); b = W'($urandom);
      exp = model(a, b, 1'b0);
      bus.a = a; bus.b = b; bus.cin = 1'b0; bus.in_valid = 1'b1;
      tick;
      bus.in_valid = 1'b0;
      cnt = 0; seen = 0;
      while (!bus.in_ready && cnt < 100) begin
        if (bus.out_valid) begin
          seen++;
          n_cmp++; if ({bus.ovf, bus.cout, bus.sum} !== exp)
            begin n_err++; $display("FAIL b2b_result_%0d got %h want %h", i, {bus.ovf, bus.cout, bus.sum}, exp); end
        end
        tick;
        cnt++;
      end
      n_cmp++; if (cnt !== NB + 1 || seen !== 1)
        begin n_err++; $display("FAIL b2b_interval_%0d got %0d cycles %0d results want %0d and 1", i, cnt, seen, NB + 1); end
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [W+1:0] res;
    int lat, rose;
    bus.a = 32'h1234_5678; bus.b = 32'h1111_1111; bus.cin = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
      begin n_err++; $display("FAIL midrst_idle got in_ready=%b out_valid=%b busy=%b want 1 0 0",
                              bus.in_ready, bus.out_valid, bus.busy); end
    rose = 0;
    for (int c = 0; c < NB + 3; c++) begin
      if (bus.out_valid) rose++;
      tick;
    end
    n_cmp++; if (rose !== 0) begin n_err++; $display("FAIL midrst_no_result got %0d valid cycles want 0", rose); end
    run_op(32'd1, 32'd2, 1'b0, 0, res, lat);
    n_cmp++; if (res !== {2'b00, 32'd3}) begin n_err++; $display("FAIL midrst_next_op got %h want %h", res, {2'b00, 32'd3}); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
